imem_prefetch_queue: RTL and testbench

IMEM_PREFETCH_QUEUE -- requirements
Module: imem_prefetch_queue

---
 rtl/imem_prefetch_queue_pkg.sv | 13 +
 rtl/imem_prefetch_queue_if.sv | 37 +++
 rtl/imem_prefetch_queue_fifo.sv | 55 +++++
 rtl/imem_prefetch_queue.sv | 76 +++++++
 tb/tb_imem_prefetch_queue.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/imem_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package imem_prefetch_queue_pkg;

  localparam int                PC_WIDTH      = 32;
  localparam int                DEPTH_DEFAULT = 4;
  localparam logic [PC_WIDTH-1:0] NOP_INSN    = 32'd0;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] insn;
  } entry_t;

endpackage

// File: rtl/imem_prefetch_queue_if.sv
// Instruction-memory, fetch-stage and redirect signals of the prefetch queue.
interface imem_prefetch_queue_if;
  import imem_prefetch_queue_pkg::*;

  logic [PC_WIDTH-1:0] address_imem;
  logic [PC_WIDTH-1:0] q_imem;
  logic                fetch_ready;
  logic                fetch_valid;
  logic [PC_WIDTH-1:0] fetch_insn;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;

  // master: the prefetch queue; slave: imem plus fetch stage around it
  modport master (
    output address_imem,
    input  q_imem,
    input  fetch_ready,
    output fetch_valid,
    output fetch_insn,
    output fetch_pc,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  address_imem,
    output q_imem,
    output fetch_ready,
    input  fetch_valid,
    input  fetch_insn,
    input  fetch_pc,
    output redirect,
    output redirect_pc
  );

endinterface

// File: rtl/imem_prefetch_queue_fifo.sv
// Circular buffer of {pc, insn} entries with a synchronous clear for flushes.
module prefetch_fifo
  import imem_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  entry_t                 push_entry_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  output entry_t                 head_entry_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL  = (PTR_W+1)'(DEPTH);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [PTR_W:0]     count_q;

  // NOTE: the storage array is deliberately not reset; count_q alone says which slots are live.
  always_ff @(posedge clock) begin
    if (push_i && !clear_i) mem_q[tail_q] <= push_entry_i;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + PTR_W'(1);
      if (pop_i)  head_q <= head_q + PTR_W'(1);
      count_q <= count_q + {{PTR_W{1'b0}}, push_i} - {{PTR_W{1'b0}}, pop_i};
    end
  end

  assign head_entry_o = mem_q[head_q];
  assign count_o      = count_q;

  no_overflow_a: assert property (@(posedge clock) disable iff (reset)
    !(push_i && !clear_i && count_q == FULL));
  no_underflow_a: assert property (@(posedge clock) disable iff (reset)
    !(pop_i && !clear_i && count_q == '0));

endmodule

// File: rtl/imem_prefetch_queue.sv
// Instruction prefetch queue: credit-based imem issue, redirect flush, head presentation.
module imem_prefetch_queue
  import imem_prefetch_queue_pkg::*;
#(
  parameter int                  DEPTH = DEPTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0] NOP   = NOP_INSN
) (
  input  logic                  clock,
  input  logic                  reset,
  imem_prefetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PC_WIDTH-1:0] next_pc_q,   next_pc_d;
  logic [PC_WIDTH-1:0] issued_pc_q, issued_pc_d;
  logic                inflight_q,  inflight_d;

  logic [CNT_W-1:0]    count;
  logic                issue;
  logic                push;
  logic                pop;
  logic                valid;
  entry_t              push_entry;
  entry_t              head_entry;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    valid       = (count != '0);
    // an issue is allowed only when a slot is reserved for it and for any response still in flight
    issue       = !bus.redirect && ((count + CNT_W'(inflight_q)) < CNT_W'(DEPTH));
    push        = inflight_q && !bus.redirect;
    pop         = valid && bus.fetch_ready && !bus.redirect;
    push_entry  = '{pc: issued_pc_q, insn: bus.q_imem};

    next_pc_d   = next_pc_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = 1'b0;
    if (bus.redirect) begin
      next_pc_d = bus.redirect_pc;
    end else if (issue) begin
      next_pc_d   = next_pc_q + 32'd1;
      issued_pc_d = next_pc_q;
      inflight_d  = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      next_pc_q   <= '0;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      next_pc_q   <= next_pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .clear_i      (bus.redirect),
    .head_entry_o (head_entry),
    .count_o      (count)
  );

  assign bus.address_imem = next_pc_q;
  assign bus.fetch_valid  = valid;
  assign bus.fetch_insn   = valid ? head_entry.insn : NOP;
  assign bus.fetch_pc     = valid ? head_entry.pc   : next_pc_q;

endmodule

// File: tb/tb_imem_prefetch_queue.sv
// Directed bench with a pc scoreboard against an imem model returning addr+0x100.
module tb_imem_prefetch_queue;
  import imem_prefetch_queue_pkg::*;

  localparam logic [31:0] TB_NOP = 32'h0000_0013;
  localparam logic [31:0] OFS    = 32'h0000_0100;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] sb [$];

  imem_prefetch_queue_if bus ();

  imem_prefetch_queue #(.DEPTH(4), .NOP(TB_NOP)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // instruction memory: data for an address appears one cycle later
  always @(posedge clock) bus.q_imem <= bus.address_imem + OFS;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic observe(input string tag);
    logic [31:0] exp_pc;
    if (bus.fetch_valid && bus.fetch_ready && !bus.redirect) begin
      if (sb.size() == 0) begin
        check({tag, " unexpected pop (sb size)"}, 32'(sb.size()), 32'd1);
      end else begin
        exp_pc = sb.pop_front();
        check({tag, " pop pc"},   bus.fetch_pc,   exp_pc);
        check({tag, " pop insn"}, bus.fetch_insn, exp_pc + OFS);
      end
    end
  endtask

  task automatic step(input string tag);
    observe(tag);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      step(tag);
    end
    check({tag, " leftover expected entries"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " valid"}, 32'(bus.fetch_valid), 32'd0);
    check({tag, " insn"},  bus.fetch_insn,       TB_NOP);
    check({tag, " pc"},    bus.fetch_pc,         32'd0);
    check({tag, " addr"},  bus.address_imem,     32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.fetch_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs("reset");

    // streaming from reset with fetch_ready held high
    sb.delete();
    for (int i = 0; i < 12; i++) sb.push_back(32'(i));
    bus.fetch_ready = 1'b1;
    reset           = 1'b0;
    check("b c0 valid", 32'(bus.fetch_valid), 32'd0);
    check("b c0 addr",  bus.address_imem,     32'd0);
    step("b");
    check("b c1 valid", 32'(bus.fetch_valid), 32'd0);
    step("b");
    check("b c2 valid", 32'(bus.fetch_valid), 32'd1);
    check("b c2 pc",    bus.fetch_pc,         32'd0);
    for (int k = 0; k < 8; k++) begin
      check("b throughput valid", 32'(bus.fetch_valid), 32'd1);
      step("b");
    end

    // asynchronous reset between clock edges
    #2 reset = 1'b1;
    #1 check_reset_outputs("async reset");
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs("held reset");

    // stalled fetch: queue fills to DEPTH and issue stops
    sb.delete();
    bus.fetch_ready = 1'b0;
    reset           = 1'b0;
    check("c restart addr", bus.address_imem, 32'd0);
    repeat (10) step("c");
    check("c count full",  32'(u_dut.u_fifo.count_q), 32'd4);
    check("c addr stuck",  bus.address_imem,          32'd4);
    check("c head valid",  32'(bus.fetch_valid),      32'd1);
    check("c head pc",     bus.fetch_pc,              32'd0);
    for (int i = 0; i < 8; i++) sb.push_back(32'(i));
    bus.fetch_ready = 1'b1;
    drain("c", 20);

    // redirect with three entries queued and one response in flight
    reset           = 1'b1;
    bus.fetch_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) step("d");
    check("d pre count",    32'(u_dut.u_fifo.count_q), 32'd3);
    check("d pre inflight", 32'(u_dut.inflight_q),     32'd1);
    sb.delete();
    sb.push_back(32'h40);
    sb.push_back(32'h41);
    sb.push_back(32'h42);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    bus.fetch_ready = 1'b1;
    step("d");
    bus.redirect = 1'b0;
    check("d r+1 valid", 32'(bus.fetch_valid), 32'd0);
    check("d r+1 addr",  bus.address_imem,     32'h40);
    step("d");
    check("d r+2 valid", 32'(bus.fetch_valid), 32'd0);
    step("d");
    check("d r+3 valid", 32'(bus.fetch_valid), 32'd1);
    check("d r+3 pc",    bus.fetch_pc,         32'h40);
    check("d r+3 insn",  bus.fetch_insn,       32'h140);
    drain("d", 10);

    // back-to-back redirects: only the second target is fetched
    sb.delete();
    sb.push_back(32'h20);
    sb.push_back(32'h21);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h10;
    step("e");
    bus.redirect_pc = 32'h20;
    check("e r2 addr",  bus.address_imem,     32'h10);
    check("e r2 valid", 32'(bus.fetch_valid), 32'd0);
    step("e");
    bus.redirect = 1'b0;
    check("e r2+1 valid", 32'(bus.fetch_valid), 32'd0);
    check("e r2+1 addr",  bus.address_imem,     32'h20);
    step("e");
    check("e r2+2 valid", 32'(bus.fetch_valid), 32'd0);
    step("e");
    check("e r2+3 valid", 32'(bus.fetch_valid), 32'd1);
    check("e r2+3 pc",    bus.fetch_pc,         32'h20);
    drain("e", 10);

    // 32-bit pc wrap
    sb.delete();
    sb.push_back(32'hFFFF_FFFE);
    sb.push_back(32'hFFFF_FFFF);
    sb.push_back(32'h0000_0000);
    sb.push_back(32'h0000_0001);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFE;
    step("g");
    bus.redirect = 1'b0;
    drain("g", 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
